// File: rtl/reg_check_unit.sv
// End-of-run register-file checker: runs the core for a bounded window, then
// compares every register against an expected store through a one-stage pipeline.
module reg_check_unit #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS     = 32,
  parameter int RUN_CYCLES   = 50,
  parameter int STOP_ON_FAIL = 0,
  localparam int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  output logic                  core_run,
  output logic [IDX_W-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0] dut_rd_data,
  input  logic [DATA_WIDTH-1:0] exp_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [IDX_W:0]        match_cnt,
  output logic                  first_fail_vld,
  output logic [IDX_W-1:0]      first_fail_idx,
  output logic                  mism_vld,
  output logic [IDX_W-1:0]      mism_idx,
  output logic [DATA_WIDTH-1:0] mism_got,
  output logic [DATA_WIDTH-1:0] mism_exp
);

  localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(NUM_REGS);
  localparam logic             STOP     = (STOP_ON_FAIL != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cyc;
  logic                  r_issued;
  logic                  r_p_vld;
  logic [IDX_W-1:0]      r_p_idx;
  logic [DATA_WIDTH-1:0] r_p_dut;
  logic [DATA_WIDTH-1:0] r_p_exp;
  logic                  r_core_run;
  logic [IDX_W-1:0]      r_rd_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [IDX_W:0]        r_match_cnt;
  logic                  r_ff_vld;
  logic [IDX_W-1:0]      r_ff_idx;
  logic                  r_mism_vld;
  logic [IDX_W-1:0]      r_mism_idx;
  logic [DATA_WIDTH-1:0] r_mism_got;
  logic [DATA_WIDTH-1:0] r_mism_exp;

  logic                  w_eq;
  logic                  w_finish;
  logic [IDX_W:0]        w_match_nxt;

  // Compare stage: equality, next match count and scan-termination decision.
  always_comb begin
    w_eq        = (r_p_dut == r_p_exp);
    w_finish    = 1'b0;
    w_match_nxt = r_match_cnt;
    if (r_p_vld) begin
      if (w_eq) begin
        w_match_nxt = r_match_cnt + 1'b1;
      end else begin
        w_match_nxt = r_match_cnt;
      end
      w_finish = (r_p_idx == LAST_IDX) || (!w_eq && STOP);
    end else begin
      w_finish = 1'b0;
    end
  end

  // Sequencer: run window, scan pipeline and all result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_issued    <= 1'b0;
      r_p_vld     <= 1'b0;
      r_p_idx     <= '0;
      r_p_dut     <= '0;
      r_p_exp     <= '0;
      r_core_run  <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_match_cnt <= '0;
      r_ff_vld    <= 1'b0;
      r_ff_idx    <= '0;
      r_mism_vld  <= 1'b0;
      r_mism_idx  <= '0;
      r_mism_got  <= '0;
      r_mism_exp  <= '0;
    end else begin
      r_mism_vld <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_core_run  <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_match_cnt <= '0;
            r_ff_vld    <= 1'b0;
            r_ff_idx    <= '0;
            r_cyc       <= '0;
            r_rd_addr   <= '0;
            r_p_vld     <= 1'b0;
            r_issued    <= 1'b0;
          end
        end
        S_RUN: begin
          if (halt || (r_cyc == LAST_CYC)) begin
            r_state    <= S_SCAN;
            r_core_run <= 1'b0;
            r_rd_addr  <= '0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_SCAN: begin
          if (r_p_vld && !w_eq) begin
            r_mism_vld <= 1'b1;
            r_mism_idx <= r_p_idx;
            r_mism_got <= r_p_dut;
            r_mism_exp <= r_p_exp;
            if (!r_ff_vld) begin
              r_ff_vld <= 1'b1;
              r_ff_idx <= r_p_idx;
            end
          end
          r_match_cnt <= w_match_nxt;
          // On a stop-on-fail exit the entry captured behind the mismatch is dropped.
          if (w_finish) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_match_nxt == FULL_CNT);
            r_p_vld <= 1'b0;
          end else if (!r_issued) begin
            r_p_vld <= 1'b1;
            r_p_idx <= r_rd_addr;
            r_p_dut <= dut_rd_data;
            r_p_exp <= exp_rd_data;
            if (r_rd_addr == LAST_IDX) begin
              r_issued <= 1'b1;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end else begin
            r_p_vld <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_core_run <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_pass     <= 1'b0;
        end
      endcase
    end
  end

  assign core_run       = r_core_run;
  assign rd_addr        = r_rd_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign match_cnt      = r_match_cnt;
  assign first_fail_vld = r_ff_vld;
  assign first_fail_idx = r_ff_idx;
  assign mism_vld       = r_mism_vld;
  assign mism_idx       = r_mism_idx;
  assign mism_got       = r_mism_got;
  assign mism_exp       = r_mism_exp;

endmodule

// File: tb/tb_reg_check_unit.sv
// Bench for reg_check_unit: two instances (compare-all and stop-on-fail) share
// stimulus; a timing-formula model is checked every cycle, plus literal pins.
module tb_reg_check_unit;

  localparam int DW = 64;
  localparam int N  = 32;
  localparam int RC = 50;

  logic clk;
  logic rst, start, halt;
  logic          core_run_w [2];
  logic [4:0]    rd_addr_w  [2];
  logic [DW-1:0] dut_rd     [2];
  logic [DW-1:0] exp_rd     [2];
  logic          busy_w     [2];
  logic          done_w     [2];
  logic          pass_w     [2];
  logic [5:0]    match_w    [2];
  logic          ffv_w      [2];
  logic [4:0]    ffi_w      [2];
  logic          mv_w       [2];
  logic [4:0]    mi_w       [2];
  logic [DW-1:0] mg_w       [2];
  logic [DW-1:0] me_w       [2];

  logic [DW-1:0] dut_mem [N];
  logic [DW-1:0] exp_mem [N];

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  bit chk_en   = 1'b0;
  int p_halt_at = 0;

  bit            m_act [2] = '{1'b0, 1'b0};
  int            m_e0 [2], m_R [2], m_L [2], m_D [2];
  logic [DW-1:0] m_dv [2][N];
  logic [DW-1:0] m_ev [2][N];

  int mism_tot  [2] = '{0, 0};
  int done_edge [2] = '{0, 0};
  bit prev_done [2] = '{1'b0, 1'b0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    assign dut_rd[g] = dut_mem[rd_addr_w[g]];
    assign exp_rd[g] = exp_mem[rd_addr_w[g]];
    reg_check_unit #(
      .DATA_WIDTH(DW), .NUM_REGS(N), .RUN_CYCLES(RC), .STOP_ON_FAIL(g)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt),
      .core_run(core_run_w[g]), .rd_addr(rd_addr_w[g]),
      .dut_rd_data(dut_rd[g]), .exp_rd_data(exp_rd[g]),
      .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]),
      .match_cnt(match_w[g]), .first_fail_vld(ffv_w[g]), .first_fail_idx(ffi_w[g]),
      .mism_vld(mv_w[g]), .mism_idx(mi_w[g]), .mism_got(mg_w[g]), .mism_exp(me_w[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Model latch: accept start when idle/done, record run window and data snapshot.
  initial forever begin
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_act[s] = 1'b0;
      end else if (start && (!m_act[s] || (edge_cnt - m_e0[s] >= m_D[s]))) begin
        m_act[s] = 1'b1;
        m_e0[s]  = edge_cnt + 1;
        m_R[s]   = (p_halt_at >= 1 && p_halt_at <= RC) ? p_halt_at : RC;
        m_L[s]   = N - 1;
        for (int k = N - 1; k >= 0; k--) begin
          m_dv[s][k] = dut_mem[k];
          m_ev[s][k] = exp_mem[k];
          if (s == 1 && dut_mem[k] !== exp_mem[k]) m_L[s] = k;
        end
        m_D[s] = m_R[s] + m_L[s] + 2;
      end
    end
    edge_cnt++;
  end

  // Per-cycle comparison: register k is compared at run-relative edge R+2+k.
  initial begin
    int t, cnt, e_rd, e_ffi, e_mi;
    bit e_core, e_busy, e_done, e_pass, e_ffv, e_mv;
    logic [DW-1:0] e_mg, e_me;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int s = 0; s < 2; s++) begin
          t = 0; cnt = 0; e_rd = 0; e_ffi = 0; e_mi = 0;
          e_core = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
          e_ffv = 1'b0; e_mv = 1'b0; e_mg = '0; e_me = '0;
          if (m_act[s]) begin
            t      = edge_cnt - m_e0[s];
            e_core = (t < m_R[s]);
            e_busy = (t < m_D[s]);
            e_done = (t >= m_D[s]);
            if (t >= m_R[s]) begin
              e_rd = t - m_R[s];
              if (e_rd > m_L[s] + 1) e_rd = m_L[s] + 1;
              if (e_rd > N - 1) e_rd = N - 1;
            end
            for (int k = 0; k <= m_L[s]; k++) begin
              if (m_R[s] + 2 + k <= t) begin
                if (m_dv[s][k] === m_ev[s][k]) cnt++;
                else if (!e_ffv) begin e_ffv = 1'b1; e_ffi = k; end
              end
              if (m_R[s] + 2 + k == t && m_dv[s][k] !== m_ev[s][k]) begin
                e_mv = 1'b1; e_mi = k; e_mg = m_dv[s][k]; e_me = m_ev[s][k];
              end
            end
            e_pass = e_done && (cnt == N);
          end
          chk($sformatf("u%0d.core_run t=%0d", s, t), 64'(core_run_w[s]), 64'(e_core));
          chk($sformatf("u%0d.busy t=%0d", s, t), 64'(busy_w[s]), 64'(e_busy));
          chk($sformatf("u%0d.done t=%0d", s, t), 64'(done_w[s]), 64'(e_done));
          chk($sformatf("u%0d.pass t=%0d", s, t), 64'(pass_w[s]), 64'(e_pass));
          chk($sformatf("u%0d.rd_addr t=%0d", s, t), 64'(rd_addr_w[s]), 64'(e_rd));
          chk($sformatf("u%0d.match_cnt t=%0d", s, t), 64'(match_w[s]), 64'(cnt));
          chk($sformatf("u%0d.ff_vld t=%0d", s, t), 64'(ffv_w[s]), 64'(e_ffv));
          chk($sformatf("u%0d.ff_idx t=%0d", s, t), 64'(ffi_w[s]), 64'(e_ffi));
          chk($sformatf("u%0d.mism_vld t=%0d", s, t), 64'(mv_w[s]), 64'(e_mv));
          if (e_mv) begin
            chk($sformatf("u%0d.mism_idx t=%0d", s, t), 64'(mi_w[s]), 64'(e_mi));
            chk($sformatf("u%0d.mism_got t=%0d", s, t), mg_w[s], e_mg);
            chk($sformatf("u%0d.mism_exp t=%0d", s, t), me_w[s], e_me);
          end
        end
      end
    end
  end

  // Event monitor: strobe totals and the edge at which done last rose.
  initial forever begin
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      if (chk_en && mv_w[s]) mism_tot[s]++;
      if (done_w[s] && !prev_done[s]) done_edge[s] = edge_cnt;
      prev_done[s] = done_w[s];
    end
  end

  task automatic fill_equal();
    for (int k = 0; k < N; k++) begin
      dut_mem[k] = {$urandom(), $urandom()};
    end
    dut_mem[0] = '0;
    for (int k = 0; k < N; k++) exp_mem[k] = dut_mem[k];
  endtask

  task automatic go(input int halt_at, input int restart_at, input int rst_at,
                    output int e0, output int rd_snap);
    p_halt_at = halt_at;
    rd_snap   = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    e0 = edge_cnt;
    for (int t = 1; t <= 300; t++) begin
      if (rst_at == 0 && done_w[0] && done_w[1]) break;
      if (rst_at > 0 && t == rst_at + 1) break;
      if (t == rst_at) rd_snap = int'(rd_addr_w[0]);
      halt  = (t == halt_at);
      start = (t == restart_at);
      rst   = (rst_at > 0 && t == rst_at);
      @(negedge clk);
    end
    halt = 1'b0; start = 1'b0; rst = 1'b0;
    if (rst_at == 0) chk("run_completes", 64'(done_w[0] & done_w[1]), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    int e0, snap, m0, m1;
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    fill_equal();
    repeat (3) @(negedge clk);
    rst = 1'b0; chk_en = 1'b1;
    chk("reset_core_run", 64'(core_run_w[0]), 64'(0));
    chk("reset_done", 64'(done_w[0]), 64'(0));
    chk("reset_match", 64'(match_w[1]), 64'(0));

    // A: all equal, start re-pulsed during RUN must not disturb timing
    m0 = mism_tot[0]; m1 = mism_tot[1];
    go(0, 10, 0, e0, snap);
    chk("A_done_edge0", 64'(done_edge[0] - e0), 64'(83));
    chk("A_done_edge1", 64'(done_edge[1] - e0), 64'(83));
    chk("A_match", 64'(match_w[0]), 64'(32));
    chk("A_pass", 64'(pass_w[0]), 64'(1));
    chk("A_strobes", 64'(mism_tot[0] - m0 + mism_tot[1] - m1), 64'(0));

    // B: mismatches at 5 and 17 (17 differs only in bit 63), restarted from DONE
    exp_mem[5]  = exp_mem[5] ^ 64'h0000_0000_00A5_1234;
    exp_mem[17] = exp_mem[17] ^ 64'h8000_0000_0000_0000;
    m0 = mism_tot[0]; m1 = mism_tot[1];
    go(0, 0, 0, e0, snap);
    chk("B_done_edge0", 64'(done_edge[0] - e0), 64'(83));
    chk("B_match0", 64'(match_w[0]), 64'(30));
    chk("B_ffi0", 64'(ffi_w[0]), 64'(5));
    chk("B_pass0", 64'(pass_w[0]), 64'(0));
    chk("B_strobes0", 64'(mism_tot[0] - m0), 64'(2));
    chk("B_done_edge1", 64'(done_edge[1] - e0), 64'(57));
    chk("B_match1", 64'(match_w[1]), 64'(5));
    chk("B_ffi1", 64'(ffi_w[1]), 64'(5));
    chk("B_strobes1", 64'(mism_tot[1] - m1), 64'(1));

    // C: halt sampled on the 3rd RUN cycle
    fill_equal();
    go(3, 0, 0, e0, snap);
    chk("C_done_edge", 64'(done_edge[0] - e0), 64'(36));
    chk("C_match", 64'(match_w[0]), 64'(32));
    chk("C_pass", 64'(pass_w[0]), 64'(1));

    // D: reset mid-scan at rd_addr=10, then a clean full run
    fill_equal();
    go(0, 0, 61, e0, snap);
    chk("D_rd_at_rst", 64'(snap), 64'(10));
    chk("D_busy", 64'(busy_w[0]), 64'(0));
    chk("D_match", 64'(match_w[0]), 64'(0));
    chk("D_rd_addr", 64'(rd_addr_w[0]), 64'(0));
    go(0, 0, 0, e0, snap);
    chk("E_done_edge", 64'(done_edge[0] - e0), 64'(83));
    chk("E_match", 64'(match_w[0]), 64'(32));

    // F: boundary indices 0 and 31 mismatch with fresh data
    fill_equal();
    dut_mem[0]  = 64'h1;
    exp_mem[31] = exp_mem[31] ^ 64'h1;
    go(0, 0, 0, e0, snap);
    chk("F_match0", 64'(match_w[0]), 64'(30));
    chk("F_ffi0", 64'(ffi_w[0]), 64'(0));
    chk("F_done_edge1", 64'(done_edge[1] - e0), 64'(52));
    chk("F_match1", 64'(match_w[1]), 64'(0));
    chk("F_ffv1", 64'(ffv_w[1]), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
